// File: rtl/mem_stage_lsu_if.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu_if
// Word-wide data-memory request/acknowledge bus between the MEM-stage LSU
// (master) and the data memory (slave).
//   dmem_req   : request, held high until dmem_ack
//   dmem_we    : 1 = write, 0 = read
//   dmem_addr  : word-aligned byte address
//   dmem_wdata : lane-replicated store data
//   dmem_be    : byte enables, bit n covers dmem_wdata[8n+7:8n]
//   dmem_ack   : one-cycle completion pulse from memory
//   dmem_rdata : read word, valid together with dmem_ack
// -----------------------------------------------------------------------------
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// MEM-stage load/store unit. Takes the MEM control bits and effective address
// from EX/MEM, runs one byte/half/word access on the data-memory bus, stalls
// the pipeline while the access is outstanding and hands the extended load
// result to MEM/WB.
//
// Ports
//   clock, reset_n           : clock (rising edge), async active-low reset
//   MEM_MEM_RDEN/WREN        : load / store request (store wins if both set)
//   MEM_ALUResult            : effective byte address
//   MEM_StoreData            : low-aligned store data
//   MEM_Size, MEM_Unsigned   : access size (00 B, 01 H, 1x W), zero-extend
//   dmem                     : data-memory bus (master side)
//   mem_stall                : freezes upstream stages, bubbles MEM/WB
//   load_data, load_valid    : extended load result and its update pulse
//   misaligned, bus_error    : one-cycle pulses for dropped/aborted accesses
//
// Optional feature: define LSU_TIMEOUT_EN to abort an access that has not
// been acknowledged after TIMEOUT WAIT cycles (bus_error pulse). Without it
// the LSU waits for dmem_ack indefinitely and bus_error is tied low.
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   MEM_MEM_RDEN,
    input  logic                   MEM_MEM_WREN,
    input  logic [31:0]            MEM_ALUResult,
    input  logic [31:0]            MEM_StoreData,
    input  logic [1:0]             MEM_Size,
    input  logic                   MEM_Unsigned,
    mem_stage_lsu_if.master        dmem,
    output logic                   mem_stall,
    output logic [31:0]            load_data,
    output logic                   load_valid,
    output logic                   misaligned,
    output logic                   bus_error
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_error_q, bus_error_d;

    logic        access;
    logic        aligned;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic [31:0] ext_c;
    logic        timeout_hit;

    assign access = MEM_MEM_RDEN | MEM_MEM_WREN;

    // Lane steering for the request and lane extraction for the response.
    // EX/MEM is frozen by mem_stall, so the size/address inputs are still
    // those of the outstanding access when dmem_ack arrives.
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        aligned = 1'b1;
        be_c    = 4'b1111;
        wdata_c = MEM_StoreData;
        case (MEM_ALUResult[1:0])
            2'd0:    byte_c = dmem.dmem_rdata[7:0];
            2'd1:    byte_c = dmem.dmem_rdata[15:8];
            2'd2:    byte_c = dmem.dmem_rdata[23:16];
            default: byte_c = dmem.dmem_rdata[31:24];
        endcase
        half_c = MEM_ALUResult[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        ext_c  = dmem.dmem_rdata;
        case (MEM_Size)
            2'b00: begin
                be_c    = 4'b0001 << MEM_ALUResult[1:0];
                wdata_c = {4{MEM_StoreData[7:0]}};
                ext_c   = MEM_Unsigned ? {24'd0, byte_c} : {{24{byte_c[7]}}, byte_c};
            end
            2'b01: begin
                aligned = ~MEM_ALUResult[0];
                be_c    = MEM_ALUResult[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{MEM_StoreData[15:0]}};
                ext_c   = MEM_Unsigned ? {16'd0, half_c} : {{16{half_c[15]}}, half_c};
            end
            default: begin
                aligned = (MEM_ALUResult[1:0] == 2'b00);
            end
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Count only unacknowledged WAIT cycles; an ack on the terminal cycle wins.
    assign timeout_hit = (state_q == ST_WAIT) && !dmem.dmem_ack &&
                         (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != ST_WAIT)
            cnt_d = '0;
        else if (!dmem.dmem_ack)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        misaligned_d = 1'b0;
        bus_error_d  = 1'b0;
        mem_stall    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (aligned) begin
                        mem_stall = 1'b1;
                        req_d     = 1'b1;
                        we_d      = MEM_MEM_WREN;
                        addr_d    = {MEM_ALUResult[31:2], 2'b00};
                        wdata_d   = wdata_c;
                        be_d      = be_c;
                        state_d   = ST_WAIT;
                    end else begin
                        misaligned_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                mem_stall = 1'b1;
                if (dmem.dmem_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        load_data_d  = ext_c;
                        load_valid_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    req_d       = 1'b0;
                    load_data_d = 32'd0;
                    bus_error_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            // Inputs still belong to the finished instruction: release the
            // stall and ignore them for this one cycle.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            load_data_q  <= 32'd0;
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            misaligned_q <= misaligned_d;
            bus_error_q  <= bus_error_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;
    assign load_data       = load_data_q;
    assign load_valid      = load_valid_q;
    assign misaligned      = misaligned_q;
    assign bus_error       = bus_error_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
// Drives directed and randomized loads/stores into mem_stage_lsu, plays the
// data memory with a configurable ack latency, and compares the bus, stall
// and load-result outputs against a byte-lane model of the access rules.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        rden, wren;
    logic [31:0] alu, sd;
    logic [1:0]  size;
    logic        uns;
    logic        mem_stall, load_valid, misaligned, bus_error;
    logic [31:0] load_data;

    mem_stage_lsu_if dmem ();

    mem_stage_lsu #(.TIMEOUT(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .MEM_MEM_RDEN  (rden),
        .MEM_MEM_WREN  (wren),
        .MEM_ALUResult (alu),
        .MEM_StoreData (sd),
        .MEM_Size      (size),
        .MEM_Unsigned  (uns),
        .dmem          (dmem),
        .mem_stall     (mem_stall),
        .load_data     (load_data),
        .load_valid    (load_valid),
        .misaligned    (misaligned),
        .bus_error     (bus_error)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_ld   = 32'd0;

    // ---------------- reference model (byte-lane view) ----------------
    function automatic int nbytes_of(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_aligned(input logic [31:0] a, input logic [1:0] s);
        return (a % nbytes_of(s)) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] s);
        int off = int'(a % 4);
        int n   = nbytes_of(s);
        logic [3:0] be = '0;
        for (int k = 0; k < 4; k++) be[k] = (k >= off) && (k < off + n);
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] s);
        int n = nbytes_of(s);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                               input logic [1:0] s, input logic u);
        int n = nbytes_of(s);
        logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
        logic [31:0] v = (rd >> (8 * (a % 4))) & mask[31:0];
        if (!u && v[8*n-1]) v = v | ~mask[31:0];
        return v;
    endfunction

    // ---------------- helpers ----------------
    task automatic clear_inputs();
        rden = 1'b0; wren = 1'b0; alu = 32'd0; sd = 32'd0; size = 2'b00; uns = 1'b0;
    endtask

    // One aligned access from IDLE through DONE; returns just after the edge
    // that leaves DONE with the access's inputs still applied.
    task automatic do_access(input string tag, input logic r, input logic w,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] s, input logic u,
                             input int delay, input logic [31:0] rd);
        int stalls = 0;
        rden = r; wren = w; alu = a; sd = d; size = s; uns = u;
        @(negedge clock);
        if (mem_stall) stalls++;
        n_checks++;
        if (dmem.dmem_req !== 1'b0 || load_valid !== 1'b0)
            $display("FAIL %s idle_outputs: req=%b load_valid=%b want 0/0", tag, dmem.dmem_req, load_valid);
        else n_pass++;
        @(posedge clock); #1;
        for (int c = 0; c <= delay; c++) begin
            dmem.dmem_ack   = (c == delay);
            dmem.dmem_rdata = (c == delay) ? rd : $urandom;
            @(negedge clock);
            if (mem_stall) stalls++;
            n_checks++;
            if (dmem.dmem_req !== 1'b1 || dmem.dmem_we !== w ||
                dmem.dmem_addr !== {a[31:2], 2'b00} || dmem.dmem_be !== model_be(a, s) ||
                dmem.dmem_wdata !== model_wdata(d, s))
                $display("FAIL %s wait_bus: req=%b we=%b addr=%h be=%b wdata=%h want 1/%b/%h/%b/%h",
                         tag, dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_be,
                         dmem.dmem_wdata, w, {a[31:2], 2'b00}, model_be(a, s), model_wdata(d, s));
            else n_pass++;
            @(posedge clock); #1;
        end
        dmem.dmem_ack = 1'b0;
        if (!w) exp_ld = model_load(rd, a, s, u);
        @(negedge clock);
        n_checks++;
        if (mem_stall !== 1'b0 || dmem.dmem_req !== 1'b0 || load_valid !== !w ||
            load_data !== exp_ld || bus_error !== 1'b0)
            $display("FAIL %s done: stall=%b req=%b lv=%b ld=%h berr=%b want 0/0/%b/%h/0",
                     tag, mem_stall, dmem.dmem_req, load_valid, load_data, bus_error, !w, exp_ld);
        else n_pass++;
        n_checks++;
        if (stalls !== delay + 2)
            $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalls, delay + 2);
        else n_pass++;
        @(posedge clock); #1;
    endtask

    task automatic do_misaligned(input string tag, input logic r, input logic w,
                                 input logic [31:0] a, input logic [1:0] s);
        rden = r; wren = w; alu = a; sd = $urandom; size = s; uns = 1'b0;
        @(negedge clock);
        n_checks++;
        if (mem_stall !== 1'b0 || dmem.dmem_req !== 1'b0)
            $display("FAIL %s mis_nostall: stall=%b req=%b want 0/0", tag, mem_stall, dmem.dmem_req);
        else n_pass++;
        @(posedge clock); #1;
        clear_inputs();
        @(negedge clock);
        n_checks++;
        if (misaligned !== 1'b1 || dmem.dmem_req !== 1'b0 || load_valid !== 1'b0 || load_data !== exp_ld)
            $display("FAIL %s mis_pulse: mis=%b req=%b lv=%b ld=%h want 1/0/0/%h",
                     tag, misaligned, dmem.dmem_req, load_valid, load_data, exp_ld);
        else n_pass++;
        @(posedge clock); #1;
        @(negedge clock);
        n_checks++;
        if (misaligned !== 1'b0)
            $display("FAIL %s mis_one_cycle: mis=%b want 0", tag, misaligned);
        else n_pass++;
        @(posedge clock); #1;
    endtask

    task automatic idle_cycle();
        clear_inputs();
        @(negedge clock);
        n_checks++;
        if (mem_stall !== 1'b0 || load_valid !== 1'b0 || misaligned !== 1'b0 || dmem.dmem_req !== 1'b0)
            $display("FAIL idle: stall=%b lv=%b mis=%b req=%b want 0/0/0/0",
                     mem_stall, load_valid, misaligned, dmem.dmem_req);
        else n_pass++;
        @(posedge clock); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 32'd0;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (dmem.dmem_req !== 1'b0 || dmem.dmem_we !== 1'b0 || dmem.dmem_addr !== 32'd0 ||
            dmem.dmem_wdata !== 32'd0 || dmem.dmem_be !== 4'd0 || load_data !== 32'd0 ||
            load_valid !== 1'b0 || misaligned !== 1'b0 || bus_error !== 1'b0 || mem_stall !== 1'b0)
            $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h be=%b ld=%h lv=%b mis=%b berr=%b stall=%b want all 0",
                     dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata, dmem.dmem_be,
                     load_data, load_valid, misaligned, bus_error, mem_stall);
        else n_pass++;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        exp_ld = 32'd0;
    endtask

    task automatic test_directed();
        do_access("word_load", 1'b1, 1'b0, 32'h100, 32'd0, 2'b10, 1'b0, 1, 32'hDEADBEEF);
        n_checks++;
        if (load_data !== 32'hDEADBEEF)
            $display("FAIL word_load_value: got %h want deadbeef", load_data);
        else n_pass++;
        idle_cycle();
        do_access("byte_signed", 1'b1, 1'b0, 32'h103, 32'd0, 2'b00, 1'b0, 0, 32'h80FF1234);
        n_checks++;
        if (load_data !== 32'hFFFFFF80)
            $display("FAIL byte_signed_value: got %h want ffffff80", load_data);
        else n_pass++;
        idle_cycle();
        do_access("byte_unsigned", 1'b1, 1'b0, 32'h103, 32'd0, 2'b00, 1'b1, 0, 32'h80FF1234);
        n_checks++;
        if (load_data !== 32'h00000080)
            $display("FAIL byte_unsigned_value: got %h want 00000080", load_data);
        else n_pass++;
        idle_cycle();
        do_access("half_store", 1'b0, 1'b1, 32'h0A2, 32'h0000ABCD, 2'b01, 1'b0, 2, 32'h11111111);
        n_checks++;
        if (dmem.dmem_wdata !== 32'hABCDABCD || dmem.dmem_be !== 4'b1100 || dmem.dmem_addr !== 32'h0A0)
            $display("FAIL half_store_bus: wdata=%h be=%b addr=%h want abcdabcd/1100/000000a0",
                     dmem.dmem_wdata, dmem.dmem_be, dmem.dmem_addr);
        else n_pass++;
        idle_cycle();
        do_misaligned("word_mis", 1'b1, 1'b0, 32'h102, 2'b10);
        do_misaligned("half_mis", 1'b0, 1'b1, 32'h0A1, 2'b01);
        // Both enables set: treated as a store, so no load_valid.
        do_access("both_en_store", 1'b1, 1'b1, 32'h204, 32'h12345678, 2'b11, 1'b0, 0, 32'hCAFEF00D);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        do_access("b2b_store", 1'b0, 1'b1, 32'h301, 32'h000000A5, 2'b00, 1'b0, 0, 32'h0);
        do_access("b2b_load1", 1'b1, 1'b0, 32'h302, 32'd0, 2'b01, 1'b0, 1, 32'h8001_7FFF);
        do_access("b2b_load2", 1'b1, 1'b0, 32'h300, 32'd0, 2'b01, 1'b1, 0, 32'h8001_F00F);
        idle_cycle();
    endtask

    task automatic test_reset_mid_access();
        rden = 1'b1; alu = 32'h400; size = 2'b10;
        @(posedge clock); #1;
        @(negedge clock);
        n_checks++;
        if (dmem.dmem_req !== 1'b1)
            $display("FAIL rst_mid_pre: req=%b want 1", dmem.dmem_req);
        else n_pass++;
        clear_inputs();
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (dmem.dmem_req !== 1'b0 || mem_stall !== 1'b0 || load_data !== 32'd0)
            $display("FAIL rst_mid_drop: req=%b stall=%b ld=%h want 0/0/0", dmem.dmem_req, mem_stall, load_data);
        else n_pass++;
        exp_ld = 32'd0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h5555AAAA;
        @(posedge clock); #1;
        dmem.dmem_ack = 1'b0;
        @(negedge clock);
        n_checks++;
        if (load_valid !== 1'b0 || dmem.dmem_req !== 1'b0 || load_data !== 32'd0)
            $display("FAIL rst_mid_stray_ack: lv=%b req=%b ld=%h want 0/0/0", load_valid, dmem.dmem_req, load_data);
        else n_pass++;
        @(posedge clock); #1;
    endtask

    task automatic test_no_ack();
        int bad = 0;
        rden = 1'b1; alu = 32'h40; size = 2'b10; uns = 1'b0;
        @(posedge clock); #1;
`ifdef LSU_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (dmem.dmem_req !== 1'b1 || bus_error !== 1'b0) bad++;
            @(posedge clock); #1;
        end
        n_checks++;
        if (bad != 0) $display("FAIL timeout_wait: %0d bad cycles want 0", bad);
        else n_pass++;
        exp_ld = 32'd0;
        @(negedge clock);
        n_checks++;
        if (bus_error !== 1'b1 || dmem.dmem_req !== 1'b0 || load_data !== 32'd0 ||
            load_valid !== 1'b0 || mem_stall !== 1'b0)
            $display("FAIL timeout_abort: berr=%b req=%b ld=%h lv=%b stall=%b want 1/0/0/0/0",
                     bus_error, dmem.dmem_req, load_data, load_valid, mem_stall);
        else n_pass++;
        @(posedge clock); #1;
`else
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (dmem.dmem_req !== 1'b1 || mem_stall !== 1'b1 || bus_error !== 1'b0) bad++;
            @(posedge clock); #1;
        end
        n_checks++;
        if (bad != 0) $display("FAIL no_ack_hold: %0d cycles lost req/stall want 0", bad);
        else n_pass++;
        dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h0BADF00D;
        @(posedge clock); #1;
        dmem.dmem_ack = 1'b0;
        exp_ld = 32'h0BADF00D;
        @(negedge clock);
        n_checks++;
        if (load_valid !== 1'b1 || load_data !== exp_ld || dmem.dmem_req !== 1'b0)
            $display("FAIL no_ack_late: lv=%b ld=%h req=%b want 1/%h/0", load_valid, load_data, dmem.dmem_req, exp_ld);
        else n_pass++;
        @(posedge clock); #1;
`endif
        idle_cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  s  = 2'($urandom_range(0, 3));
            logic [31:0] a  = $urandom;
            logic        r  = 1'($urandom);
            logic        w  = 1'($urandom);
            if (!r && !w) r = 1'b1;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes_of(s) - 1);
            if (!is_aligned(a, s))
                do_misaligned($sformatf("rnd%0d", i), r, w, a, s);
            else
                do_access($sformatf("rnd%0d", i), r, w, a, $urandom, s, 1'($urandom),
                          int'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_access();
        test_no_ack();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
